// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master memory arbiter: FSM states, one-hot grant codes,
// default timeout and the round-robin pick rule.
package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_REQ0 = 2'b01;
   localparam logic [1:0] GNT_REQ1 = 2'b10;

   localparam int TMO_CYC_DEF = 255;

   // Returns 1 when requester 1 should be granted; a tie goes to whoever was not served last.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
      if (req0 && req1) return ~last;
      return req1 & ~req0;
   endfunction

   function automatic logic [1:0] grant_code(input logic sel);
      return sel ? GNT_REQ1 : GNT_REQ0;
   endfunction

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Per-transaction timeout: down-counter loaded at grant, terminal count flags expiry.
// A TMO_CYC of zero disables expiry entirely.
module mem_arbiter_timeout #(
   parameter int TMO_CYC = 255,
   parameter int TMO_W   = 8
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic load,
   input  logic cnt_en,
   output logic expired
);

   localparam logic [TMO_W-1:0] LOAD_VAL = (TMO_CYC == 0) ? '0 : TMO_W'(TMO_CYC - 1);

   logic [TMO_W-1:0] cnt;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt_en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (TMO_CYC != 0) && (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, one transaction in
// flight, registered memory strobes and a timeout that aborts with an error pulse.
//
// state   | meaning
// IDLE    | sample requests, grant one and launch strobes
// BUSY    | strobes held, waiting for iMemRdy or timeout
// DONE    | strobes low, Rdy/Err pulse to winner, then back to IDLE
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = TMO_CYC_DEF,
   parameter int TMO_W   = 8
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic [ADDR_W-1:0] iReq0Addr,
   input  logic [DATA_W-1:0] iReq0Data,
   input  logic              iReq0Read,
   input  logic              iReq0Write,
   output logic [DATA_W-1:0] oReq0Data,
   output logic              oReq0Rdy,
   output logic              oReq0Err,
   input  logic [ADDR_W-1:0] iReq1Addr,
   input  logic [DATA_W-1:0] iReq1Data,
   input  logic              iReq1Read,
   input  logic              iReq1Write,
   output logic [DATA_W-1:0] oReq1Data,
   output logic              oReq1Rdy,
   output logic              oReq1Err,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemData,
   input  logic [DATA_W-1:0] iMemData,
   input  logic              iMemRdy,
   output logic              oMemRead,
   output logic              oMemWrite,
   output logic [1:0]        oGrant
);

   logic [1:0] state;
   logic       winner;
   logic       last_served;
   logic       req0_any;
   logic       req1_any;
   logic       pick;
   logic       tmo_load;
   logic       tmo_cnt_en;
   logic       expired;

   assign req0_any   = iReq0Read | iReq0Write;
   assign req1_any   = iReq1Read | iReq1Write;
   assign pick       = rr_pick(req0_any, req1_any, last_served);
   assign tmo_load   = (state == ST_IDLE) && (req0_any || req1_any);
   assign tmo_cnt_en = (state == ST_BUSY) && !iMemRdy;

   mem_arbiter_timeout #(
      .TMO_CYC (TMO_CYC),
      .TMO_W   (TMO_W)
   ) u_timeout (
      .clk_sys (iClk),
      .rst     (iRst),
      .load    (tmo_load),
      .cnt_en  (tmo_cnt_en),
      .expired (expired)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state       <= ST_IDLE;
         winner      <= 1'b0;
         last_served <= 1'b1;
         oMemAddr    <= '0;
         oMemData    <= '0;
         oMemRead    <= 1'b0;
         oMemWrite   <= 1'b0;
         oGrant      <= GNT_NONE;
         oReq0Data   <= '0;
         oReq1Data   <= '0;
         oReq0Rdy    <= 1'b0;
         oReq1Rdy    <= 1'b0;
         oReq0Err    <= 1'b0;
         oReq1Err    <= 1'b0;
      end else begin
         oReq0Rdy <= 1'b0;
         oReq1Rdy <= 1'b0;
         oReq0Err <= 1'b0;
         oReq1Err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req0_any || req1_any) begin
                  winner    <= pick;
                  oGrant    <= grant_code(pick);
                  oMemAddr  <= pick ? iReq1Addr : iReq0Addr;
                  oMemData  <= pick ? iReq1Data : iReq0Data;
                  oMemWrite <= pick ? iReq1Write : iReq0Write;
                  oMemRead  <= pick ? (iReq1Read & ~iReq1Write) : (iReq0Read & ~iReq0Write);
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Ready takes priority over a timeout landing on the same cycle.
               if (iMemRdy || expired) begin
                  oMemRead    <= 1'b0;
                  oMemWrite   <= 1'b0;
                  oGrant      <= GNT_NONE;
                  last_served <= winner;
                  state       <= ST_DONE;
                  if (iMemRdy) begin
                     if (winner) begin
                        oReq1Rdy <= 1'b1;
                        if (oMemRead) oReq1Data <= iMemData;
                     end else begin
                        oReq0Rdy <= 1'b1;
                        if (oMemRead) oReq0Data <= iMemData;
                     end
                  end else begin
                     if (winner) begin
                        oReq1Err  <= 1'b1;
                        oReq1Data <= '0;
                     end else begin
                        oReq0Err  <= 1'b1;
                        oReq0Data <= '0;
                     end
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grant order, strobe
// windows, completion/timeout pulses and returned data; a second instance covers TMO_CYC=0.
module tb_mem_arbiter;

   localparam int TMO = 4;

   logic        iClk;
   logic        iRst;
   logic [31:0] iReq0Addr, iReq0Data, iReq1Addr, iReq1Data, iMemData;
   logic        iReq0Read, iReq0Write, iReq1Read, iReq1Write, iMemRdy;
   logic [31:0] oReq0Data, oReq1Data, oMemAddr, oMemData;
   logic        oReq0Rdy, oReq0Err, oReq1Rdy, oReq1Err, oMemRead, oMemWrite;
   logic [1:0]  oGrant;
   logic [31:0] nt_data0, nt_data1, nt_addr, nt_mdata;
   logic        nt_rdy0, nt_err0, nt_rdy1, nt_err1, nt_rd, nt_wr;
   logic [1:0]  nt_gnt;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO), .TMO_W(8)) dut (
      .iClk(iClk), .iRst(iRst),
      .iReq0Addr(iReq0Addr), .iReq0Data(iReq0Data), .iReq0Read(iReq0Read), .iReq0Write(iReq0Write),
      .oReq0Data(oReq0Data), .oReq0Rdy(oReq0Rdy), .oReq0Err(oReq0Err),
      .iReq1Addr(iReq1Addr), .iReq1Data(iReq1Data), .iReq1Read(iReq1Read), .iReq1Write(iReq1Write),
      .oReq1Data(oReq1Data), .oReq1Rdy(oReq1Rdy), .oReq1Err(oReq1Err),
      .oMemAddr(oMemAddr), .oMemData(oMemData), .iMemData(iMemData), .iMemRdy(iMemRdy),
      .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oGrant(oGrant)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(0), .TMO_W(8)) dut_nt (
      .iClk(iClk), .iRst(iRst),
      .iReq0Addr(iReq0Addr), .iReq0Data(iReq0Data), .iReq0Read(iReq0Read), .iReq0Write(iReq0Write),
      .oReq0Data(nt_data0), .oReq0Rdy(nt_rdy0), .oReq0Err(nt_err0),
      .iReq1Addr(iReq1Addr), .iReq1Data(iReq1Data), .iReq1Read(iReq1Read), .iReq1Write(iReq1Write),
      .oReq1Data(nt_data1), .oReq1Rdy(nt_rdy1), .oReq1Err(nt_err1),
      .oMemAddr(nt_addr), .oMemData(nt_mdata), .iMemData(iMemData), .iMemRdy(iMemRdy),
      .oMemRead(nt_rd), .oMemWrite(nt_wr), .oGrant(nt_gnt)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   // Transaction-level model state
   bit          own_v = 0;
   int          own, s_cyc, end_cyc, wait_n;
   bit          own_err;
   bit          last = 1;
   bit          pend [2];
   bit          t_rd [2];
   bit          t_wr [2];
   logic [31:0] t_addr [2];
   logic [31:0] t_data [2];
   bit          l_rd, l_wr;
   logic [31:0] l_addr, l_data, l_rdval;
   logic [31:0] exp_data [2];
   logic [31:0] mem [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic drive_req(input int r, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d);
      if (r == 0) begin
         iReq0Read = rd; iReq0Write = wr; iReq0Addr = a; iReq0Data = d;
      end else begin
         iReq1Read = rd; iReq1Write = wr; iReq1Addr = a; iReq1Data = d;
      end
   endtask

   // One cycle: check outputs against the model, then drive inputs for the next edge.
   task automatic step(input bit rst_now, input int req_pct);
      bit         busy, done, scr;
      int         k, w;
      logic [1:0] e_gnt;
      @(negedge iClk);
      cyc++;
      busy = own_v && (cyc >= s_cyc) && (cyc < end_cyc);
      done = own_v && (cyc == end_cyc);
      if (done) begin
         if (own_err) exp_data[own] = '0;
         else if (l_rd && !l_wr) exp_data[own] = l_rdval;
         last = (own == 1);
         pend[own] = 0;
      end
      e_gnt = busy ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("grant", 32'(oGrant), 32'(e_gnt));
      check("mem_read", 32'(oMemRead), 32'(busy && l_rd && !l_wr));
      check("mem_write", 32'(oMemWrite), 32'(busy && l_wr));
      if (busy) begin
         check("mem_addr", oMemAddr, l_addr);
         if (l_wr) check("mem_data", oMemData, l_data);
      end
      check("rdy0", 32'(oReq0Rdy), 32'(done && own == 0 && !own_err));
      check("rdy1", 32'(oReq1Rdy), 32'(done && own == 1 && !own_err));
      check("err0", 32'(oReq0Err), 32'(done && own == 0 && own_err));
      check("err1", 32'(oReq1Err), 32'(done && own == 1 && own_err));
      check("data0", oReq0Data, exp_data[0]);
      check("data1", oReq1Data, exp_data[1]);

      if (rst_now) begin
         iRst = 1'b1;
         own_v = 0; last = 1;
         pend[0] = 0; pend[1] = 0;
         exp_data[0] = '0; exp_data[1] = '0;
         drive_req(0, 0, 0, '0, '0);
         drive_req(1, 0, 0, '0, '0);
         iMemRdy = 1'b0;
         return;
      end
      iRst = 1'b0;

      // Memory side: ready after wait_n low cycles; random ready noise outside BUSY.
      if (own_v && (cyc == s_cyc + wait_n)) begin
         iMemRdy  = 1'b1;
         iMemData = (l_rd && !l_wr) ? l_rdval : $urandom;
      end else if (busy) begin
         iMemRdy  = 1'b0;
         iMemData = $urandom;
      end else begin
         iMemRdy  = ($urandom_range(0, 3) == 0);
         iMemData = $urandom;
      end

      for (int r = 0; r < 2; r++) begin
         if (!pend[r] && ($urandom_range(0, 99) < req_pct)) begin
            pend[r]   = 1;
            k         = $urandom_range(0, 2);
            t_rd[r]   = (k != 1);
            t_wr[r]   = (k != 0);
            t_addr[r] = 32'($urandom_range(0, 15));
            t_data[r] = $urandom;
         end
         scr = busy && (own == r);
         if (pend[r])
            drive_req(r, t_rd[r], t_wr[r], scr ? $urandom : t_addr[r], scr ? $urandom : t_data[r]);
         else
            drive_req(r, 0, 0, $urandom, $urandom);
      end

      if ((!own_v || cyc > end_cyc) && (pend[0] || pend[1])) begin
         w       = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
         own     = w;
         own_v   = 1;
         s_cyc   = cyc + 1;
         wait_n  = $urandom_range(0, 5);
         own_err = (wait_n >= TMO);
         end_cyc = own_err ? s_cyc + TMO : s_cyc + wait_n + 1;
         l_rd    = t_rd[w];
         l_wr    = t_wr[w];
         l_addr  = t_addr[w];
         l_data  = t_data[w];
         l_rdval = mem[l_addr[3:0]];
         if (l_wr && !own_err) mem[l_addr[3:0]] = l_data;
      end
   endtask

   initial begin
      int bad;
      bit found;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      exp_data[0] = '0; exp_data[1] = '0;
      pend[0] = 0; pend[1] = 0;
      iRst = 1'b1; iMemRdy = 1'b0; iMemData = '0;
      drive_req(0, 0, 0, '0, '0);
      drive_req(1, 0, 0, '0, '0);
      repeat (3) @(posedge iClk);

      step(0, 0);
      repeat (40) step(0, 100);
      repeat (1500) step(0, 40);

      found = 0;
      for (int i = 0; i < 300; i++) begin
         step(0, 60);
         if (own_v && (cyc + 1 >= s_cyc) && (cyc + 1 < end_cyc)) begin
            found = 1;
            break;
         end
      end
      check("rst_in_busy_reached", 32'(found), 32'd1);
      step(1, 0);
      repeat (30) step(0, 100);

      // Timeout disabled instance: request must stay outstanding for 1000 cycles.
      step(1, 0);
      @(negedge iClk);
      iRst = 1'b0; iMemRdy = 1'b0;
      drive_req(0, 1, 0, 32'h5, 32'h77);
      drive_req(1, 0, 0, '0, '0);
      bad = 0;
      repeat (1000) begin
         @(negedge iClk);
         if (nt_rd !== 1'b1 || nt_wr !== 1'b0 || nt_gnt !== 2'b01 || nt_addr !== 32'h5 ||
             nt_mdata !== 32'h77 || nt_rdy0 || nt_err0 || nt_rdy1 || nt_err1 ||
             nt_data0 !== 32'h0 || nt_data1 !== 32'h0)
            bad++;
      end
      check("nt_wait_1000", 32'(bad), 32'd0);
      iMemRdy = 1'b1; iMemData = 32'hCAFEF00D;
      @(negedge iClk);
      iMemRdy = 1'b0;
      drive_req(0, 0, 0, '0, '0);
      check("nt_rdy0", 32'(nt_rdy0), 32'd1);
      check("nt_data0", nt_data0, 32'hCAFEF00D);
      check("nt_strobe_drop", 32'(nt_rd), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
